// File: rtl/ring_seq_monitor.sv
// Receive-side checker for a one-hot left-rotating ring word: decodes the set bit to a
// binary phase, checks single-step rotation, tracks lock and counts errors.
module ring_seq_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8,
    localparam int IW      = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             clear_err,
    output logic [IW-1:0]    idx,
    output logic             idx_valid,
    output logic             onehot_ok,
    output logic             locked,
    output logic             seq_err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = ($clog2(LOCK_CNT + 1) > 1) ? $clog2(LOCK_CNT + 1) : 1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic onehot_legal(input logic [WIDTH-1:0] w);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) n = n + 1;
        end
        return (n == 1);
    endfunction

    function automatic logic [IW-1:0] onehot_index(input logic [WIDTH-1:0] w);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) r = IW'(i);
        end
        return r;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    state_t            state_p1, state_nxt;
    logic [IW-1:0]     prev_p1, prev_nxt;
    logic [GW-1:0]     good_p1, good_nxt, good_inc;
    logic [IW-1:0]     idx_nxt;
    logic              idx_vld_nxt, onehot_nxt, err_nxt, wrap_nxt;
    logic [ERR_W-1:0]  cnt_nxt;

    // ---- stage p0: decode the sampled word ----
    logic              legal_p0;
    logic [IW-1:0]     index_p0, expect_p0;

    assign legal_p0  = onehot_legal(ring_in);
    assign index_p0  = onehot_index(ring_in);
    assign expect_p0 = (prev_p1 == IW'(WIDTH - 1)) ? '0 : prev_p1 + IW'(1);
    assign good_inc  = good_p1 + GW'(1);

    always_comb begin
        state_nxt   = state_p1;
        prev_nxt    = prev_p1;
        good_nxt    = good_p1;
        idx_nxt     = idx;
        onehot_nxt  = onehot_ok;
        idx_vld_nxt = 1'b0;
        err_nxt     = 1'b0;
        wrap_nxt    = 1'b0;
        if (in_valid) begin
            onehot_nxt = legal_p0;
            if (!legal_p0) begin
                err_nxt   = 1'b1;
                state_nxt = HUNT;
                good_nxt  = '0;
            end else begin
                idx_nxt     = index_p0;
                prev_nxt    = index_p0;
                idx_vld_nxt = 1'b1;
                case (state_p1)
                    TRACK, LOCKED: begin
                        if (index_p0 == expect_p0) begin
                            if (state_p1 == TRACK) begin
                                good_nxt = good_inc;
                                if (good_inc == GW'(LOCK_CNT)) state_nxt = LOCKED;
                            end else begin
                                wrap_nxt = (index_p0 == '0);
                            end
                        end else begin
                            // Any wrong step, including a repeat, resyncs onto the new index.
                            err_nxt   = 1'b1;
                            state_nxt = TRACK;
                            good_nxt  = '0;
                        end
                    end
                    default: begin
                        state_nxt = TRACK;
                        good_nxt  = '0;
                    end
                endcase
            end
        end
        if (clear_err) cnt_nxt = err_nxt ? ERR_W'(1) : '0;
        else if (err_nxt) cnt_nxt = sat_inc(err_count);
        else cnt_nxt = err_count;
    end

    // ---- stage p1: registered state and outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1  <= HUNT;
            prev_p1   <= '0;
            good_p1   <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            onehot_ok <= 1'b0;
            seq_err   <= 1'b0;
            wrap      <= 1'b0;
            err_count <= '0;
        end else begin
            state_p1  <= state_nxt;
            prev_p1   <= prev_nxt;
            good_p1   <= good_nxt;
            idx       <= idx_nxt;
            idx_valid <= idx_vld_nxt;
            onehot_ok <= onehot_nxt;
            seq_err   <= err_nxt;
            wrap      <= wrap_nxt;
            err_count <= cnt_nxt;
        end
    end

    assign locked = (state_p1 == LOCKED);

endmodule
